module_multiplicador: RTL and testbench
=======================================

# module_multiplicador

Sequential signed multiplier directly downstream of `module_teclado`. It captures the two 8-bit two's-complement operands the keypad produces (`first_num`, `second_num`) on a start pulse. It computes their 16-bit signed product with radix-2 Booth recoding, one step per clock, and presents the result with a one-cycle `done` pulse to the display/formatting stage.

## Interface
- `WIDTH`, default 8: operand width in bits; product is 2·WIDTH bits.

Ports:
- `clk`  in  1: system clock (27 MHz); all state updates on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request to multiply; sampled only in IDLE.
- `first_num`  in  WIDTH: multiplicand, two's complement.
- `second_num`  in  WIDTH: multiplier, two's complement.
- `busy`  out  1: high while in CALC or DONE.
- `done`  out  1: one-cycle pulse; `product` is valid from this cycle on.
- `product`  out  2·WIDTH: signed result; holds until the next completion.

## Operation
- Three states:
  - IDLE: `busy`=0.
    - `start`=1 at an edge latches `first_num` into M (sign-extended to WIDTH+1 bits) and `second_num` into Q.
    - The same edge clears accumulator A (WIDTH+1 bits), Booth bit q₋₁ and step counter, and moves to CALC.
  - CALC: one Booth step per cycle.
    - On {Q[0], q₋₁}: 01 → A+=M; 10 → A−=M; 00/11 → no add.
    - Then arithmetic right shift of {A, Q, q₋₁} by one, with the sign of A replicated.
    - Counter increments. After the WIDTH-th step, `product` is loaded from {A[WIDTH−1:0], Q} and the state moves to DONE.
  - DONE: `done`=1 for exactly this one cycle, then unconditionally back to IDLE.
- The accumulator is WIDTH+1 bits so −2^(WIDTH−1) as multiplicand negates without overflow. The full product range, including (−128)·(−128)=+16384, is exact; no saturation or overflow flag.
- `start` while `busy`=1 is ignored (not queued). Operand inputs may change freely after the capture edge without affecting the result.
- `start` held high continuously: a new operation begins on the first IDLE edge after DONE. That gives back-to-back operations every WIDTH+2 cycles.
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, internal registers 0.
- Reset during CALC or DONE aborts the operation. `product` returns to 0 and no `done` is issued.
- Reset has priority over `start` in the same cycle.

## Timing
- Cycle S: `start`=1 sampled in IDLE at edge S.
- Cycles S+1 … S+WIDTH: CALC steps; `busy`=1 from S+1.
- `product` updates at edge S+WIDTH. `done`=1 and `busy`=1 during cycle S+WIDTH+1.
- Cycle S+WIDTH+2: IDLE, `busy`=0; a new `start` is accepted at this edge.
- Latency start→done = WIDTH+1 cycles (9 for WIDTH=8).
- `product` is stable everywhere except the single load edge. The consumer samples on `done`, or at any later time before the next `done`.
- `done` is never high in two consecutive cycles.

## Test plan
- 12 × 34, start pulse one cycle → `done` exactly 9 cycles after the start edge; `product`=16'h0198 (408); `busy` high for 9 cycles.
- −12 (8'hF4) × 34 → 16'hFE68 (−408). Then 34 × −12 → 16'hFE68. Then −1 × −1 → 16'h0001.
- Corner operands: −128 × −128 → 16'h4000. Then −128 × 127 → 16'hC080. Then 0 × −77 → 16'h0000.
- Busy rejection: start 5 × 6, pulse `start` with 9 × 9 during CALC → single `done`, `product`=16'h001E; no second `done`.
- Continuous `start` high with 3 × 3 → `done` pulses every 10 cycles, `product`=16'h0009 each time, `busy` low for one cycle between operations.
- Reset mid-CALC (4 cycles after start of 7 × 7) → next cycle `busy`=0, `product`=0, no `done`. A fresh 7 × 7 afterwards → 16'h0031 after 9 cycles.

Source files
------------

// File: rtl/module_multiplicador.sv
// module_multiplicador: sequential signed multiplier using radix-2 Booth recoding, one step per clock.
module module_multiplicador #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   first_num,
    input  logic [WIDTH-1:0]   second_num,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic signed [WIDTH:0] a, m, sum;
    logic [WIDTH-1:0]      q;
    logic                  qm;
    logic [CW-1:0]         cnt;
    logic [2*WIDTH+1:0]    shifted;

    // One extra accumulator bit keeps -M exact when M is the most negative operand.
    always_comb begin
        sum     = ({q[0], qm} == 2'b01) ? a + m : ({q[0], qm} == 2'b10) ? a - m : a;
        shifted = $signed({sum, q, qm}) >>> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a       <= '0;
            m       <= '0;
            q       <= '0;
            qm      <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    m     <= {first_num[WIDTH-1], first_num};
                    q     <= second_num;
                    a     <= '0;
                    qm    <= 1'b0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    a   <= shifted[2*WIDTH+1:WIDTH+1];
                    q   <= shifted[WIDTH:1];
                    qm  <= shifted[0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product <= shifted[2*WIDTH:1];
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_module_multiplicador.sv
// tb_module_multiplicador: directed and random multiplications checked against plain signed arithmetic.
module tb_module_multiplicador;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  first_num = '0;
    logic [7:0]  second_num = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;
    int          checks = 0;
    int          failures = 0;

    module_multiplicador #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .first_num(first_num),
        .second_num(second_num), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'($signed(x)) * int'($signed(y));
        return p[15:0];
    endfunction

    task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input string tag);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        first_num = x; second_num = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_num = 8'($urandom); second_num = 8'($urandom);
        cyc = 1; busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 9);
        check({tag, " busy_calc"}, busy_cnt, 8);
        check({tag, " busy_done"}, {31'b0, busy}, 1);
        check({tag, " product"}, {16'b0, product}, {16'b0, ref_mul(x, y)});
        @(negedge clk);
        check({tag, " done_once"}, {31'b0, done}, 0);
        check({tag, " idle"}, {31'b0, busy}, 0);
    endtask

    initial begin
        int nd;
        int idle_cnt;
        int q_done[$];
        logic [15:0] last_p;
        repeat (2) @(negedge clk);
        check("rst busy", {31'b0, busy}, 0);
        check("rst done", {31'b0, done}, 0);
        check("rst product", {16'b0, product}, 0);
        start = 1'b1; first_num = 8'd3; second_num = 8'd3;
        @(negedge clk);
        check("rst prio", {31'b0, busy}, 0);
        rst = 1'b0; start = 1'b0;

        do_mul(8'd12, 8'd34, "12x34");
        check("12x34 const", {16'b0, product}, 32'h0198);
        do_mul(8'hF4, 8'd34, "-12x34");
        check("-12x34 const", {16'b0, product}, 32'hFE68);
        do_mul(8'd34, 8'hF4, "34x-12");
        do_mul(8'hFF, 8'hFF, "-1x-1");
        do_mul(8'h80, 8'h80, "-128x-128");
        check("-128x-128 const", {16'b0, product}, 32'h4000);
        do_mul(8'h80, 8'h7F, "-128x127");
        check("-128x127 const", {16'b0, product}, 32'hC080);
        do_mul(8'd0, 8'hB3, "0x-77");
        check("product holds", {16'b0, product}, 0);

        // Busy rejection: second start during CALC must be dropped
        @(negedge clk);
        first_num = 8'd5; second_num = 8'd6; start = 1'b1;
        nd = 0; last_p = '0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin first_num = 8'd9; second_num = 8'd9; end
            if (done) begin nd++; last_p = product; end
        end
        start = 1'b0;
        check("busy_rej dones", nd, 1);
        check("busy_rej product", {16'b0, last_p}, 32'h001E);

        // Continuous start: one operation every 10 cycles
        @(negedge clk);
        first_num = 8'd3; second_num = 8'd3; start = 1'b1;
        idle_cnt = 0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (done) begin
                q_done.push_back(i);
                check("cont product", {16'b0, product}, 32'h0009);
            end
            if (i >= 10 && i <= 29 && !busy) idle_cnt++;
        end
        start = 1'b0;
        check("cont count", q_done.size(), 3);
        if (q_done.size() >= 3) begin
            check("cont first", q_done[0], 9);
            check("cont gap1", q_done[1] - q_done[0], 10);
            check("cont gap2", q_done[2] - q_done[1], 10);
        end
        check("cont idle", idle_cnt, 2);
        nd = 0;
        while (busy && nd < 20) begin @(negedge clk); nd++; end
        check("cont drain", {31'b0, busy}, 0);

        // Reset mid-CALC aborts without done
        @(negedge clk);
        first_num = 8'd7; second_num = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {31'b0, busy}, 0);
        check("abort product", {16'b0, product}, 0);
        check("abort done", {31'b0, done}, 0);
        nd = 0;
        repeat (12) begin @(negedge clk); if (done) nd++; end
        check("abort no done", nd, 0);
        do_mul(8'd7, 8'd7, "7x7");
        check("7x7 const", {16'b0, product}, 32'h0031);

        for (int i = 0; i < 20; i++) do_mul(8'($urandom), 8'($urandom), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
